cast5_gb_seq: RTL and testbench

CAST5_GB_SEQ -- requirements
Module: cast5_gb_seq

---
 rtl/cast5_pkg.sv | 16 +
 rtl/cast5_gb_lane.sv | 20 ++
 rtl/cast5_gb_seq.sv | 123 ++++++++++++
 tb/tb_cast5_gb_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cast5_pkg.sv
// Shared types and helpers for the CAST5 byte-select sequencer.
package cast5_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/cast5_gb_lane.sv
// Combinational GB(x,i) selector: index 0 is the most significant byte of x.
module cast5_gb_lane #(
  parameter int DW = 128,
  parameter int IW = 4
) (
  input  logic [DW-1:0] x,
  input  logic [IW-1:0] i,
  output logic [7:0]    gb
);

  localparam int NB = DW / 8;

  always_comb begin
    gb = 8'h00;
    for (int b = 0; b < NB; b++) begin
      if (i == IW'(NB - 1 - b)) gb = x[8*b +: 8];
    end
  end

endmodule

// File: rtl/cast5_gb_seq.sv
// Captures a word and streams selected bytes LANES at a time with wrap-around.
// Optional descending order via CAST5_GB_SEQ_REV_EN (adds input i_rev).
module cast5_gb_seq
  import cast5_pkg::*;
#(
  parameter  int DW    = 128,
  parameter  int LANES = 1,
  localparam int NB    = DW / 8,
  localparam int IW    = clog2(DW / 8)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_vld,
  output logic                 o_rdy,
  input  logic [DW-1:0]        i_din,
  input  logic [IW-1:0]        i_start,
  input  logic [IW:0]          i_cnt,
`ifdef CAST5_GB_SEQ_REV_EN
  input  logic                 i_rev,
`endif
  output logic                 o_vld,
  input  logic                 i_rdy,
  output logic [8*LANES-1:0]   o_dout,
  output logic [LANES-1:0]     o_keep,
  output logic                 o_last,
  output logic                 o_busy
);

  state_t          state, state_nx;
  logic [DW-1:0]   word, word_nx;
  logic [IW-1:0]   idx, idx_nx;
  logic [IW:0]     rem, rem_nx;
  logic [IW:0]     cnt_clip;
  logic [IW:0]     step;
  logic            run;
  logic            capture;
  logic            beat_done;
  logic            rev;

`ifdef CAST5_GB_SEQ_REV_EN
  logic rev_nx;
`else
  assign rev = 1'b0;
`endif

  assign run       = (state == RUN);
  assign cnt_clip  = (i_cnt > (IW+1)'(NB)) ? (IW+1)'(NB) : i_cnt;
  assign step      = (rem > (IW+1)'(LANES)) ? (IW+1)'(LANES) : rem;
  assign capture   = i_vld && o_rdy;
  assign beat_done = o_vld && i_rdy;

  always_comb begin
    o_vld  = run;
    o_busy = run;
    o_last = run && (rem <= (IW+1)'(LANES));
    o_rdy  = !run || (o_last && i_rdy);
  end

  // A capture always wins over the last-beat handshake so back-to-back words need no bubble.
  always_comb begin
    state_nx = state;
    word_nx  = word;
    idx_nx   = idx;
    rem_nx   = rem;
`ifdef CAST5_GB_SEQ_REV_EN
    rev_nx   = rev;
`endif
    if (capture) begin
      word_nx  = i_din;
      idx_nx   = i_start;
      rem_nx   = cnt_clip;
`ifdef CAST5_GB_SEQ_REV_EN
      rev_nx   = i_rev;
`endif
      state_nx = (cnt_clip == '0) ? IDLE : RUN;
    end else if (beat_done) begin
      idx_nx = rev ? (idx - IW'(LANES)) : (idx + IW'(LANES));
      rem_nx = rem - step;
      if (o_last) state_nx = IDLE;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      word  <= '0;
      idx   <= '0;
      rem   <= '0;
`ifdef CAST5_GB_SEQ_REV_EN
      rev   <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      word  <= word_nx;
      idx   <= idx_nx;
      rem   <= rem_nx;
`ifdef CAST5_GB_SEQ_REV_EN
      rev   <= rev_nx;
`endif
    end
  end

  // NB is a power of two, so IW-bit arithmetic gives the mod-NB wrap for free.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [IW-1:0] sel;
    logic [7:0]    gb;

    assign sel = rev ? (idx - IW'(k)) : (idx + IW'(k));

    cast5_gb_lane #(
      .DW(DW),
      .IW(IW)
    ) u_lane (
      .x (word),
      .i (sel),
      .gb(gb)
    );

    assign o_keep[k]       = run && ((IW+1)'(k) < rem);
    assign o_dout[8*k +: 8] = o_keep[k] ? gb : 8'h00;
  end

endmodule

// File: tb/tb_cast5_gb_seq.sv
// Directed bench for cast5_gb_seq: LANES=1 and LANES=4 instances share clock and reset.
module tb_cast5_gb_seq;

  localparam logic [127:0] X = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  typedef struct {
    logic [31:0] dout;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         d1_vld, d1_rdy, d1_ovld, d1_irdy, d1_last, d1_busy;
  logic [127:0] d1_din;
  logic [3:0]   d1_start;
  logic [4:0]   d1_cnt;
  logic [7:0]   d1_dout;
  logic [0:0]   d1_keep;
  logic         d4_vld, d4_rdy, d4_ovld, d4_irdy, d4_last, d4_busy;
  logic [127:0] d4_din;
  logic [3:0]   d4_start;
  logic [4:0]   d4_cnt;
  logic [31:0]  d4_dout;
  logic [3:0]   d4_keep;
`ifdef CAST5_GB_SEQ_REV_EN
  logic         d1_rev, d4_rev;
`endif

  beat_t q1[$];
  beat_t q4[$];
  int    passed = 0;
  int    failed = 0;
  int    total  = 0;

  always #5 clk = ~clk;

  cast5_gb_seq #(.DW(128), .LANES(1)) u_d1 (
    .i_clk(clk), .i_rst(rst), .i_vld(d1_vld), .o_rdy(d1_rdy), .i_din(d1_din),
    .i_start(d1_start), .i_cnt(d1_cnt),
`ifdef CAST5_GB_SEQ_REV_EN
    .i_rev(d1_rev),
`endif
    .o_vld(d1_ovld), .i_rdy(d1_irdy), .o_dout(d1_dout), .o_keep(d1_keep),
    .o_last(d1_last), .o_busy(d1_busy)
  );

  cast5_gb_seq #(.DW(128), .LANES(4)) u_d4 (
    .i_clk(clk), .i_rst(rst), .i_vld(d4_vld), .o_rdy(d4_rdy), .i_din(d4_din),
    .i_start(d4_start), .i_cnt(d4_cnt),
`ifdef CAST5_GB_SEQ_REV_EN
    .i_rev(d4_rev),
`endif
    .o_vld(d4_ovld), .i_rdy(d4_irdy), .o_dout(d4_dout), .o_keep(d4_keep),
    .o_last(d4_last), .o_busy(d4_busy)
  );

  function automatic logic [7:0] gb(input logic [127:0] x, input int i);
    return x[8*(15-i) +: 8];
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_beat(input int which, input logic [31:0] dout, input logic [3:0] keep,
                             input logic last);
    beat_t b;
    b.dout = dout;
    b.keep = keep;
    b.last = last;
    if (which == 1) q1.push_back(b);
    else q4.push_back(b);
  endtask

  // Reference model: walks idx/rem the way the byte stream is described, one beat at a time.
  task automatic push_model(input int which, input logic [127:0] x, input int start, input int cnt,
                            input bit rev);
    int    rem, idx, pos;
    beat_t b;
    rem = (cnt > 16) ? 16 : cnt;
    idx = start;
    while (rem > 0) begin
      b.dout = '0;
      b.keep = '0;
      for (int k = 0; k < which; k++) begin
        if (k < rem) begin
          pos = rev ? (idx - k + 16) % 16 : (idx + k) % 16;
          b.dout[8*k +: 8] = gb(x, pos);
          b.keep[k] = 1'b1;
        end
      end
      b.last = (rem <= which);
      if (which == 1) q1.push_back(b);
      else q4.push_back(b);
      idx = rev ? (idx - which + 16) % 16 : (idx + which) % 16;
      rem = rem - ((rem < which) ? rem : which);
    end
  endtask

  task automatic apply_stimulus(input int which, input logic [127:0] x, input int start,
                                input int cnt, input bit rev, input bit use_model);
    if (which == 1) begin
      d1_vld = 1'b1; d1_din = x; d1_start = 4'(start); d1_cnt = 5'(cnt);
`ifdef CAST5_GB_SEQ_REV_EN
      d1_rev = rev;
`endif
    end else begin
      d4_vld = 1'b1; d4_din = x; d4_start = 4'(start); d4_cnt = 5'(cnt);
`ifdef CAST5_GB_SEQ_REV_EN
      d4_rev = rev;
`endif
    end
    #1;
    check_output("offer_rdy", (which == 1) ? 32'(d1_rdy) : 32'(d4_rdy), 32'd1);
    if (use_model) push_model(which, x, start, cnt, rev);
    @(negedge clk);
    d1_vld = 1'b0;
    d4_vld = 1'b0;
  endtask

  task automatic check_beat(input int which, input bit pop, input string tag);
    beat_t       e;
    logic        vld, last;
    logic [31:0] dout;
    logic [3:0]  keep;
    int          avail;
    avail = (which == 1) ? q1.size() : q4.size();
    check_output({tag, "_avail"}, 32'(avail != 0), 32'd1);
    if (avail == 0) return;
    if (which == 1) begin
      e = pop ? q1.pop_front() : q1[0];
      vld = d1_ovld; dout = {24'h0, d1_dout}; keep = {3'b0, d1_keep}; last = d1_last;
    end else begin
      e = pop ? q4.pop_front() : q4[0];
      vld = d4_ovld; dout = d4_dout; keep = d4_keep; last = d4_last;
    end
    check_output({tag, "_vld"}, 32'(vld), 32'd1);
    check_output({tag, "_dout"}, dout, e.dout);
    check_output({tag, "_keep"}, 32'(keep), 32'(e.keep));
    check_output({tag, "_last"}, 32'(last), 32'(e.last));
  endtask

  task automatic check_idle(input int which, input string tag);
    if (which == 1) begin
      check_output({tag, "_vld"}, 32'(d1_ovld), 32'd0);
      check_output({tag, "_busy"}, 32'(d1_busy), 32'd0);
      check_output({tag, "_rdy"}, 32'(d1_rdy), 32'd1);
    end else begin
      check_output({tag, "_vld"}, 32'(d4_ovld), 32'd0);
      check_output({tag, "_busy"}, 32'(d4_busy), 32'd0);
      check_output({tag, "_rdy"}, 32'(d4_rdy), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1;
    d1_vld = 1'b0; d1_din = '0; d1_start = '0; d1_cnt = '0; d1_irdy = 1'b0;
    d4_vld = 1'b0; d4_din = '0; d4_start = '0; d4_cnt = '0; d4_irdy = 1'b0;
`ifdef CAST5_GB_SEQ_REV_EN
    d1_rev = 1'b0; d4_rev = 1'b0;
`endif
    #2;
    check_output("rst_d1_rdy", 32'(d1_rdy), 32'd1);
    check_output("rst_d1_vld", 32'(d1_ovld), 32'd0);
    check_output("rst_d1_last", 32'(d1_last), 32'd0);
    check_output("rst_d1_busy", 32'(d1_busy), 32'd0);
    check_output("rst_d1_keep", 32'(d1_keep), 32'd0);
    check_output("rst_d1_dout", 32'(d1_dout), 32'd0);
    check_output("rst_d4_rdy", 32'(d4_rdy), 32'd1);
    check_output("rst_d4_vld", 32'(d4_ovld), 32'd0);
    check_output("rst_d4_keep", 32'(d4_keep), 32'd0);
    check_output("rst_d4_dout", d4_dout, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    d1_irdy = 1'b1;
    d4_irdy = 1'b1;

    // Full 16-byte walk, one byte per cycle.
    apply_stimulus(1, X, 0, 16, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      check_beat(1, 1'b1, "seq16");
      @(negedge clk);
    end
    check_idle(1, "seq16_end");

    // Index wrap from 14 back through 0.
    expect_beat(1, 32'hEE, 4'h1, 1'b0);
    expect_beat(1, 32'hFF, 4'h1, 1'b0);
    expect_beat(1, 32'h00, 4'h1, 1'b0);
    expect_beat(1, 32'h11, 4'h1, 1'b1);
    apply_stimulus(1, X, 14, 4, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_beat(1, 1'b1, "wrap");
      @(negedge clk);
    end
    check_idle(1, "wrap_end");

    // Four lanes with a partial final beat.
    expect_beat(4, 32'h33221100, 4'b1111, 1'b0);
    expect_beat(4, 32'h00005544, 4'b0011, 1'b1);
    apply_stimulus(4, X, 0, 6, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check_beat(4, 1'b1, "l4_part");
      @(negedge clk);
    end
    check_idle(4, "l4_part_end");

    // Backpressure on beat 2, then a second word taken on the last handshake.
    apply_stimulus(4, X, 0, 6, 1'b0, 1'b1);
    check_beat(4, 1'b1, "stall_b1");
    @(negedge clk);
    d4_irdy = 1'b0;
    repeat (3) begin
      #1;
      check_beat(4, 1'b0, "stall_hold");
      check_output("stall_rdy", 32'(d4_rdy), 32'd0);
      @(negedge clk);
    end
    d4_irdy = 1'b1;
    check_beat(4, 1'b1, "stall_b2");
    apply_stimulus(4, X, 8, 4, 1'b0, 1'b1);
    check_beat(4, 1'b1, "nobubble");
    @(negedge clk);
    check_idle(4, "nobubble_end");

    // Count above NB is clamped to NB.
    apply_stimulus(4, X, 4, 20, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check_beat(4, 1'b1, "clamp");
      @(negedge clk);
    end
    check_idle(4, "clamp_end");

    // Reset mid-word drops the remaining beats immediately.
    apply_stimulus(1, X, 0, 16, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check_beat(1, 1'b1, "prerst");
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    check_output("midrst_vld", 32'(d1_ovld), 32'd0);
    check_output("midrst_rdy", 32'(d1_rdy), 32'd1);
    check_output("midrst_dout", 32'(d1_dout), 32'd0);
    check_output("midrst_keep", 32'(d1_keep), 32'd0);
    check_output("midrst_busy", 32'(d1_busy), 32'd0);
    q1.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_output("postrst_vld", 32'(d1_ovld), 32'd0);
    end

    // Zero count consumes the word without a beat.
    apply_stimulus(1, X, 5, 0, 1'b0, 1'b1);
    check_idle(1, "cnt0");
    @(negedge clk);
    check_idle(1, "cnt0_after");

`ifdef CAST5_GB_SEQ_REV_EN
    expect_beat(1, 32'h33, 4'h1, 1'b0);
    expect_beat(1, 32'h22, 4'h1, 1'b0);
    expect_beat(1, 32'h11, 4'h1, 1'b0);
    expect_beat(1, 32'h00, 4'h1, 1'b1);
    apply_stimulus(1, X, 3, 4, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_beat(1, 1'b1, "rev");
      @(negedge clk);
    end
    check_idle(1, "rev_end");
    d1_rev = 1'b0;
`endif

    check_output("q1_drained", 32'(q1.size()), 32'd0);
    check_output("q4_drained", 32'(q4.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
